// File: rtl/ldmx_regresp_pkg.sv
// Shared address map and handshake state type for the DPM strobe/ack register responder.
package ldmx_regresp_pkg;

  localparam logic [7:0] CTRL_BASE  = 8'h00;
  localparam logic [7:0] STAT_BASE  = 8'h40;
  localparam logic [7:0] ERR_ADDR   = 8'h7D;
  localparam logic [7:0] PULSE_ADDR = 8'h7E;
  localparam logic [7:0] CNT_ADDR   = 8'h7F;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } hs_state_t;

endpackage

// File: rtl/ldmx_strobe_edge.sv
// Rising-edge detector for a level strobe. History resets to 1 so a strobe
// already high when reset releases is not mistaken for a new request.
module ldmx_strobe_edge (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b1;
    else     prev <= strobe;
  end

  assign rise = strobe & ~prev;

endmodule

// File: rtl/ldmx_reg_responder.sv
// Strobe/ack register responder: control/status banks plus transaction and error counters.
// Optional one-cycle pulse register at 0x7E is enabled by defining LDMX_REGRESP_PULSE_EN.
module ldmx_reg_responder
  import ldmx_regresp_pkg::*;
#(
  parameter int          N_CTRL   = 8,
  parameter int          N_STAT   = 8,
  parameter logic [31:0] CTRL_RST = 32'h0
) (
  input  logic                  axilClk,
  input  logic                  axilRst,
  input  logic                  axi_wstr,
  input  logic                  axi_rstr,
  input  logic [7:0]            axi_waddr,
  input  logic [7:0]            axi_raddr,
  input  logic [31:0]           axi_din,
  output logic                  axi_wack,
  output logic                  axi_rack,
  output logic [31:0]           axi_dout,
  output logic [N_CTRL*32-1:0]  ctrl_out,
  input  logic [N_STAT*32-1:0]  stat_in,
  output logic [31:0]           pulse_out
);

`ifdef LDMX_REGRESP_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  localparam logic [7:0] N_CTRL_B = 8'(N_CTRL);
  localparam logic [7:0] STAT_END = 8'(STAT_BASE + N_STAT);

  logic        w_rise, r_rise, w_acc, r_acc;
  hs_state_t   w_state, r_state;
  logic [31:0] ctrl_reg [N_CTRL];
  logic [15:0] wr_cnt, rd_cnt;
  logic [31:0] err_cnt;

  logic [7:0]  w_off, r_off, s_off;
  logic        w_ctrl, w_clr, w_pulse, w_bad;
  logic        r_ctrl, r_stat, r_special, r_bad;
  logic [31:0] rd_data;

  ldmx_strobe_edge u_wedge (
    .clk    (axilClk),
    .rst    (axilRst),
    .strobe (axi_wstr),
    .rise   (w_rise)
  );

  ldmx_strobe_edge u_redge (
    .clk    (axilClk),
    .rst    (axilRst),
    .strobe (axi_rstr),
    .rise   (r_rise)
  );

  assign w_acc = (w_state == IDLE) && w_rise;
  assign r_acc = (r_state == IDLE) && r_rise;

  always_comb begin
    w_off   = 8'(axi_waddr - CTRL_BASE);
    w_ctrl  = w_off < N_CTRL_B;
    w_clr   = axi_waddr == CNT_ADDR;
    w_pulse = PULSE_EN && (axi_waddr == PULSE_ADDR);
    w_bad   = !(w_ctrl || w_clr || w_pulse);
  end

  // Read mux; the counter words return their values from before this accept.
  always_comb begin
    r_off     = 8'(axi_raddr - CTRL_BASE);
    s_off     = 8'(axi_raddr - STAT_BASE);
    r_ctrl    = r_off < N_CTRL_B;
    r_special = (axi_raddr == ERR_ADDR) || (axi_raddr == PULSE_ADDR) || (axi_raddr == CNT_ADDR);
    r_stat    = (axi_raddr >= STAT_BASE) && (axi_raddr < STAT_END) && !r_special;
    rd_data   = 32'h0;
    r_bad     = 1'b0;
    if (r_ctrl) begin
      for (int k = 0; k < N_CTRL; k++)
        if (8'(k) == r_off) rd_data = ctrl_reg[k];
    end else if (r_stat) begin
      for (int k = 0; k < N_STAT; k++)
        if (8'(k) == s_off) rd_data = stat_in[32*k +: 32];
    end else if (axi_raddr == ERR_ADDR) begin
      rd_data = err_cnt;
    end else if (axi_raddr == CNT_ADDR) begin
      rd_data = {rd_cnt, wr_cnt};
    end else if (axi_raddr == PULSE_ADDR && PULSE_EN) begin
      rd_data = 32'h0;
    end else begin
      r_bad = 1'b1;
    end
  end

  // Both handshake FSMs run independently; dout only moves on a read accept.
  always_ff @(posedge axilClk) begin
    if (axilRst) begin
      w_state  <= IDLE;
      r_state  <= IDLE;
      axi_wack <= 1'b0;
      axi_rack <= 1'b0;
      axi_dout <= 32'h0;
    end else begin
      case (w_state)
        IDLE: if (w_rise) begin
          w_state  <= ACK;
          axi_wack <= 1'b1;
        end
        ACK: if (!axi_wstr) begin
          w_state  <= IDLE;
          axi_wack <= 1'b0;
        end
        default: w_state <= IDLE;
      endcase
      case (r_state)
        IDLE: if (r_rise) begin
          r_state  <= ACK;
          axi_rack <= 1'b1;
          axi_dout <= rd_data;
        end
        ACK: if (!axi_rstr) begin
          r_state  <= IDLE;
          axi_rack <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge axilClk) begin
    if (axilRst) begin
      for (int k = 0; k < N_CTRL; k++) ctrl_reg[k] <= CTRL_RST;
      wr_cnt  <= 16'h0;
      rd_cnt  <= 16'h0;
      err_cnt <= 32'h0;
    end else begin
      if (w_acc && w_ctrl)
        for (int k = 0; k < N_CTRL; k++)
          if (8'(k) == w_off) ctrl_reg[k] <= axi_din;
      err_cnt <= err_cnt + {31'b0, w_acc && w_bad} + {31'b0, r_acc && r_bad};
      // The clearing write is itself left uncounted.
      if (w_acc && w_clr) begin
        wr_cnt <= 16'h0;
        rd_cnt <= 16'h0;
      end else begin
        if (w_acc) wr_cnt <= wr_cnt + 16'd1;
        if (r_acc) rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end

  for (genvar k = 0; k < N_CTRL; k++) begin : g_ctrl
    assign ctrl_out[32*k +: 32] = ctrl_reg[k];
  end

`ifdef LDMX_REGRESP_PULSE_EN
  always_ff @(posedge axilClk) begin
    if (axilRst)                pulse_out <= 32'h0;
    else if (w_acc && w_pulse)  pulse_out <= axi_din;
    else                        pulse_out <= 32'h0;
  end
`else
  assign pulse_out = 32'h0;
`endif

endmodule
